// File: rtl/eeprom_pkg.sv
// Shared definitions for the 24LC04 command scheduler.
//   RSP_*   : response status codes returned on rsp_err
//   OP_*    : command type encodings for cmd_rw / eng_rw / rsp_rw
//   state_t : scheduler FSM states
//   cmd_t   : one 17-bit FIFO entry {rw, addr, wdata}
package eeprom_pkg;

  localparam logic [1:0] RSP_OK   = 2'b00;
  localparam logic [1:0] RSP_NACK = 2'b01;
  localparam logic [1:0] RSP_TMO  = 2'b10;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_RESP,
    ST_WR_WAIT
  } state_t;

  typedef struct packed {
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
  } cmd_t;

endpackage

// File: rtl/eeprom_cmd_fifo.sv
// Synchronous command FIFO, first-word-fall-through head output.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push       : write push_data when not full
//   push_data  : entry to store
//   pop        : drop the head entry when not empty
//   head       : current head entry (valid while empty=0)
//   full/empty : fill-level flags derived from the count register
module eeprom_cmd_fifo
  import eeprom_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  cmd_t push_data,
  input  logic pop,
  output cmd_t head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  cmd_t           mem [DEPTH];
  logic [AW-1:0]  wr_ptr_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [AW:0]    count_reg;
  logic           do_push;
  logic           do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr_reg];

  // Storage carries no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/eeprom_cmd_sched.sv
// Command scheduler in front of the I2C 24LC04 byte engine.
// Buffers host byte-write / random-read commands, issues them one at a
// time over a level req / pulse done handshake, waits tWR after every
// acknowledged write, aborts a transaction that runs past TIMEOUT_CYC and
// returns exactly one response per command.
//   cmd_*  : host command stream (valid/ready)
//   rsp_*  : host response stream (valid held until ready)
//   eng_*  : I2C engine request / completion
//   busy   : FSM active or commands still queued
module eeprom_cmd_sched
  import eeprom_pkg::*;
#(
  parameter int CLK_FRQ     = 50000000,
  parameter int TWR_US      = 5000,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_rw,
  output logic [7:0] rsp_data,
  output logic [1:0] rsp_err,
  output logic       eng_req,
  output logic       eng_rw,
  output logic [7:0] eng_addr,
  output logic [7:0] eng_wdata,
  input  logic       eng_done,
  input  logic       eng_nack,
  input  logic [7:0] eng_rdata,
  output logic       busy
);

  localparam int TWR_CYC = (CLK_FRQ / 1000000) * TWR_US;
  localparam int TMO_W   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int TWR_W   = (TWR_CYC > 2) ? $clog2(TWR_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [TWR_W-1:0] TWR_LAST = TWR_W'(TWR_CYC - 1);

  state_t            state_reg, state_next;
  logic [TMO_W-1:0]  tmo_cnt_reg;
  logic [TWR_W-1:0]  twr_cnt_reg;
  logic              eng_req_reg;
  cmd_t              eng_cmd_reg;
  logic              rsp_valid_reg;
  logic              rsp_rw_reg;
  logic [7:0]        rsp_data_reg;
  logic [1:0]        rsp_err_reg;

  logic              fifo_full, fifo_empty, fifo_pop;
  cmd_t              fifo_head, fifo_in;

  assign fifo_in = '{rw: cmd_rw, addr: cmd_addr, wdata: cmd_wdata};

  eeprom_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd_valid),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign cmd_ready = ~fifo_full;
  assign busy      = (state_reg != ST_IDLE) | ~fifo_empty;
  assign eng_req   = eng_req_reg;
  assign eng_rw    = eng_cmd_reg.rw;
  assign eng_addr  = eng_cmd_reg.addr;
  assign eng_wdata = eng_cmd_reg.wdata;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rw    = rsp_rw_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_err   = rsp_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    fifo_pop   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE:     state_next = ST_WAIT_DONE;
      // eng_done and the timeout both leave for RESP; the datapath
      // gives eng_done priority when they coincide.
      ST_WAIT_DONE: if (eng_done || (tmo_cnt_reg == TMO_LAST)) state_next = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          if ((rsp_rw_reg == OP_WRITE) && (rsp_err_reg == RSP_OK)) state_next = ST_WR_WAIT;
          else                                                      state_next = ST_IDLE;
        end
      end
      ST_WR_WAIT:   if (twr_cnt_reg == TWR_LAST) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_req_reg   <= 1'b0;
      eng_cmd_reg   <= '0;
      tmo_cnt_reg   <= '0;
      twr_cnt_reg   <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rw_reg    <= 1'b0;
      rsp_data_reg  <= 8'h00;
      rsp_err_reg   <= RSP_OK;
    end else begin
      case (state_reg)
        ST_IDLE: if (fifo_pop) eng_cmd_reg <= fifo_head;
        ST_ISSUE: begin
          eng_req_reg <= 1'b1;
          tmo_cnt_reg <= '0;
        end
        ST_WAIT_DONE: begin
          if (eng_done) begin
            eng_req_reg   <= 1'b0;
            rsp_valid_reg <= 1'b1;
            rsp_rw_reg    <= eng_cmd_reg.rw;
            rsp_err_reg   <= eng_nack ? RSP_NACK : RSP_OK;
            rsp_data_reg  <= ((eng_cmd_reg.rw == OP_READ) && !eng_nack) ? eng_rdata : 8'h00;
          end else if (tmo_cnt_reg == TMO_LAST) begin
            eng_req_reg   <= 1'b0;
            rsp_valid_reg <= 1'b1;
            rsp_rw_reg    <= eng_cmd_reg.rw;
            rsp_err_reg   <= RSP_TMO;
            rsp_data_reg  <= 8'h00;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            twr_cnt_reg   <= '0;
          end
        end
        ST_WR_WAIT: if (twr_cnt_reg != TWR_LAST) twr_cnt_reg <= twr_cnt_reg + 1'b1;
        default: ;
      endcase
    end
  end

endmodule
